// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - memory_bus interface shared by requesters and the memory port
interface memory_bus;
  logic [29:0] addr;
  logic [31:0] dataD;
  logic [31:0] dataQ;
  logic        read;
  logic        write;
  logic        ready;
  logic [3:0]  byteSel;

  modport master (
    output addr, dataD, read, write, byteSel,
    input  dataQ, ready
  );

  modport slave (
    input  addr, dataD, read, write, byteSel,
    output dataQ, ready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester round-robin arbiter for one single-port memory
// Zero-latency grant from IDLE, ownership held until ready, abandon or timeout abort.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  memory_bus.slave   instBus,
  memory_bus.slave   dataBus,
  memory_bus.master  memBus,
  output logic       busErr_o,
  output logic [1:0] owner_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       last_grant;   // 0: inst served last, 1: data served last
  logic [7:0] wait_cnt;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;
  logic timeout;

  always_comb begin
    req_i   = instBus.read | instBus.write;
    req_d   = dataBus.read | dataBus.write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    // A BUSY owner that drops its request loses the grant immediately.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_i && (!req_d || last_grant)) begin
            grant_i = 1'b1;
          end else if (req_d) begin
            grant_d = 1'b1;
          end
        end
        BUSY_I:  grant_i = req_i;
        BUSY_D:  grant_d = req_d;
        default: begin
          grant_i = 1'b0;
          grant_d = 1'b0;
        end
      endcase
    end
    timeout = (state != IDLE) && (grant_i || grant_d) && !memBus.ready
              && (wait_cnt == TIMEOUT_LAST);
  end

  assign memBus.addr    = grant_d ? dataBus.addr  : instBus.addr;
  assign memBus.dataD   = grant_d ? dataBus.dataD : instBus.dataD;
  assign memBus.read    = (grant_i & instBus.read)  | (grant_d & dataBus.read);
  assign memBus.write   = (grant_i & instBus.write) | (grant_d & dataBus.write);
  assign memBus.byteSel = grant_i ? instBus.byteSel :
                          grant_d ? dataBus.byteSel : 4'b0000;

  // A timeout abort completes the access towards the owner with zero data.
  assign instBus.ready  = grant_i & (memBus.ready | timeout);
  assign dataBus.ready  = grant_d & (memBus.ready | timeout);
  assign instBus.dataQ  = (grant_i && memBus.ready) ? memBus.dataQ : 32'h0000_0000;
  assign dataBus.dataQ  = (grant_d && memBus.ready) ? memBus.dataQ : 32'h0000_0000;

  assign busErr_o = timeout;
  assign owner_o  = {grant_d, grant_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            if (memBus.ready) begin
              last_grant <= 1'b0;
            end else begin
              state    <= BUSY_I;
              wait_cnt <= 8'd0;
            end
          end else if (grant_d) begin
            if (memBus.ready) begin
              last_grant <= 1'b1;
            end else begin
              state    <= BUSY_D;
              wait_cnt <= 8'd0;
            end
          end
        end
        BUSY_I: begin
          if (!req_i) begin
            state <= IDLE;
          end else if (memBus.ready || timeout) begin
            state      <= IDLE;
            last_grant <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BUSY_D: begin
          if (!req_d) begin
            state <= IDLE;
          end else if (memBus.ready || timeout) begin
            state      <= IDLE;
            last_grant <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector and sequence bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam logic [29:0] I_ADDR = 30'h10;
  localparam logic [29:0] D_ADDR = 30'h2000;
  localparam logic [31:0] I_D    = 32'h1111_1111;
  localparam logic [31:0] D_D    = 32'h2222_2222;
  localparam logic [3:0]  I_BS   = 4'hF;
  localparam logic [3:0]  D_BS   = 4'h3;
  localparam logic [31:0] MEM_Q  = 32'hCAFE_F00D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_err;
  logic [1:0] owner;
  int         total = 0;
  int         bad = 0;

  memory_bus ib ();
  memory_bus db ();
  memory_bus mb ();

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .instBus  (ib.slave),
    .dataBus  (db.slave),
    .memBus   (mb.master),
    .busErr_o (bus_err),
    .owner_o  (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ir, iw, dr, dw, mrdy;
    logic [1:0] owner;
    logic       irdy, drdy, mr, mw;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic iw,
                       input logic dr, input logic dw, input logic mrdy);
    @(negedge clk);
    rst      = r;
    ib.read  = ir;
    ib.write = iw;
    db.read  = dr;
    db.write = dw;
    mb.ready = mrdy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] e_owner,
                            input logic e_irdy, input logic e_drdy,
                            input logic [31:0] e_iq, input logic [31:0] e_dq,
                            input logic e_mr, input logic e_mw, input logic e_err);
    chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
    chk({tag, ".inst_ready"}, 32'(ib.ready), 32'(e_irdy));
    chk({tag, ".data_ready"}, 32'(db.ready), 32'(e_drdy));
    chk({tag, ".inst_q"}, ib.dataQ, e_iq);
    chk({tag, ".data_q"}, db.dataQ, e_dq);
    chk({tag, ".mem_read"}, 32'(mb.read), 32'(e_mr));
    chk({tag, ".mem_write"}, 32'(mb.write), 32'(e_mw));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(e_err));
    if (e_owner == 2'b01) begin
      chk({tag, ".mem_addr"}, 32'(mb.addr), 32'(I_ADDR));
      chk({tag, ".mem_dataD"}, mb.dataD, I_D);
      chk({tag, ".mem_bs"}, 32'(mb.byteSel), 32'(I_BS));
    end else if (e_owner == 2'b10) begin
      chk({tag, ".mem_addr"}, 32'(mb.addr), 32'(D_ADDR));
      chk({tag, ".mem_dataD"}, mb.dataD, D_D);
      chk({tag, ".mem_bs"}, 32'(mb.byteSel), 32'(D_BS));
    end else begin
      chk({tag, ".mem_bs"}, 32'(mb.byteSel), 32'h0);
    end
  endtask

  initial begin
    ib.addr = I_ADDR; ib.dataD = I_D; ib.byteSel = I_BS; ib.read = 1'b0; ib.write = 1'b0;
    db.addr = D_ADDR; db.dataD = D_D; db.byteSel = D_BS; db.read = 1'b0; db.write = 1'b0;
    mb.dataQ = MEM_Q; mb.ready = 1'b0;

    // ir iw dr dw mrdy | owner irdy drdy mr mw ; round-robin starts with inst
    vecs[0] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 1, 2'b01, 1, 0, 1, 0};
    vecs[2] = '{1, 0, 1, 0, 1, 2'b10, 0, 1, 1, 0};
    vecs[3] = '{1, 0, 1, 0, 1, 2'b01, 1, 0, 1, 0};
    vecs[4] = '{1, 0, 1, 0, 1, 2'b10, 0, 1, 1, 0};
    vecs[5] = '{1, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0};
    vecs[6] = '{0, 0, 0, 1, 1, 2'b10, 0, 1, 0, 1};
    vecs[7] = '{0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0};
    vecs[8] = '{0, 1, 1, 0, 1, 2'b01, 1, 0, 0, 1};

    drive(1, 1, 0, 1, 0, 1);
    expect_out("reset", 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      drive(0, vecs[i].ir, vecs[i].iw, vecs[i].dr, vecs[i].dw, vecs[i].mrdy);
      expect_out($sformatf("vec%0d", i), vecs[i].owner, vecs[i].irdy, vecs[i].drdy,
                 vecs[i].irdy ? MEM_Q : 32'h0, vecs[i].drdy ? MEM_Q : 32'h0,
                 vecs[i].mr, vecs[i].mw, 1'b0);
    end

    // data write held 4 cycles while inst waits, then inst times out
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0, 1, 0);
      expect_out($sformatf("hold_d%0d", c), 2'b10, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    end
    drive(0, 1, 0, 0, 1, 1);
    expect_out("hold_done", 2'b10, 0, 1, 32'h0, MEM_Q, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("inst_after", 2'b01, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0, 0, 0);
      expect_out($sformatf("to_wait%0d", c), 2'b01, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 0);
    expect_out("timeout", 2'b01, 1, 0, 32'h0, 32'h0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    expect_out("after_to", 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // ready coinciding with the timeout cycle wins
    drive(0, 0, 0, 1, 0, 0);
    expect_out("co_grant", 2'b10, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      expect_out($sformatf("co_wait%0d", c), 2'b10, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    end
    drive(0, 0, 0, 1, 0, 1);
    expect_out("co_done", 2'b10, 0, 1, 32'h0, MEM_Q, 1, 0, 0);

    // abandon leaves round-robin state untouched (data was last)
    drive(0, 1, 0, 0, 0, 0);
    expect_out("ab_grant", 2'b01, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    expect_out("ab_drop", 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 1);
    expect_out("ab_rr", 2'b01, 1, 0, MEM_Q, 32'h0, 1, 0, 0);

    // reset during BUSY_D
    drive(0, 0, 0, 1, 0, 0);
    expect_out("rs_grant", 2'b10, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    expect_out("rs_busy", 2'b10, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 1);
    expect_out("rs_hit", 2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 1);
    expect_out("rs_after", 2'b01, 1, 0, MEM_Q, 32'h0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles a granted access waits for memBus.ready before being aborted (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port instBus, memory_bus.slave, -, the instruction-fetch requester (addr 30, dataD 32, dataQ 32, read, write, ready, byteSel 4).
REQ-005 SHALL have port dataBus, memory_bus.slave, -, the load/store requester, same fields.
REQ-006 SHALL have port memBus, memory_bus.master, -, the shared single-port memory.
REQ-007 SHALL have port busErr_o, output, 1, a one-cycle pulse on a timeout abort.
REQ-008 SHALL have port owner_o, output, 2, the current owner: 00 none, 01 inst, 10 data.

Function
REQ-009 Request of a port SHALL be (read | write); a requester holds addr/dataD/byteSel/read/write stable until its ready is seen.
REQ-010 States SHALL be IDLE, BUSY_I, BUSY_D.
REQ-011 In IDLE with exactly one request, that port SHALL be granted combinationally in the same cycle (zero added latency).
REQ-012 In IDLE with both requesting, grant SHALL go to the port not granted last (round-robin via 1-bit lastGrant register).
REQ-013 Granted port's addr, dataD, byteSel, read, write SHALL be forwarded to memBus; with no grant memBus.read = memBus.write = 0, byteSel = 0000, addr/dataD don't-care.
REQ-014 memBus.dataQ and memBus.ready SHALL be forwarded only to the granted port; the non-granted port sees ready = 0, dataQ = 0.
REQ-015 If memBus.ready is asserted in the grant cycle, the access completes in that cycle, lastGrant updates, state stays IDLE.
REQ-016 Otherwise state SHALL move to BUSY_I/BUSY_D and hold ownership; requests from the other port are ignored until release.
REQ-017 In BUSY_x, the cycle memBus.ready = 1 SHALL complete the access; next state IDLE; lastGrant = x; the other port is arbitrated no earlier than the next cycle.
REQ-018 In BUSY_x, if the owner deasserts both read and write, the access SHALL be abandoned; next state IDLE; lastGrant unchanged.
REQ-019 A wait counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without ready.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1 without ready, the owner SHALL receive ready = 1 with dataQ = 32'h00000000, busErr_o SHALL pulse for that cycle, memBus.read/write SHALL drop next cycle, next state IDLE, lastGrant = x.
REQ-021 memBus.ready arriving in the same cycle as the timeout SHALL take priority: normal completion, no busErr_o.
REQ-022 memBus.ready while no grant is active SHALL be ignored.
REQ-023 owner_o SHALL reflect the grant combinationally (including zero-latency grant in IDLE).

Reset
REQ-024 During rst = 1: state IDLE, lastGrant = data (so inst wins the first conflict), counter 0, busErr_o 0, memBus.read/write 0, both port readys 0.
REQ-025 rst asserted mid-access SHALL abandon the access at the next edge with no ready and no busErr_o delivered.

Verification
REQ-026 Inst-only read addr 30'h10, memBus.ready 1 same cycle -> instBus.ready 1 with dataQ, owner_o 01 that cycle, state IDLE.
REQ-027 Both request at first cycle after reset -> inst granted; after its ready, data granted next cycle; repeat with both asserted -> alternation I, D, I, D.
REQ-028 Data write, memBus.ready after 3 cycles while inst requests -> instBus.ready stays 0 throughout, memBus carries data addr/dataD/byteSel for 4 cycles, inst granted the cycle after.
REQ-029 TIMEOUT_CYCLES = 4, memory never ready -> owner gets ready with dataQ 0 and busErr_o pulses in the 4th BUSY-window cycle, state IDLE next cycle.
REQ-030 Ready and timeout coincide -> memory dataQ delivered, busErr_o 0.
REQ-031 rst pulsed during BUSY_D -> next cycle owner_o 00, memBus.read/write 0, no ready to dataBus.
